// File: rtl/irq_pkg.sv
// irq_pkg: shared types, defaults and the pending-vector scan helper for irq_arbiter.
//   irq_state_e        arbiter FSM states
//   IRQ_N_SRC_DEFAULT  default number of interrupt sources
//   irq_first_set      first set bit of vec scanning upward from start, wrapping at bit 31
package irq_pkg;

    localparam int IRQ_N_SRC_DEFAULT = 16;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_e;

    // Bits above the real source count are zero, so wrapping at 31 behaves
    // exactly like wrapping at N_SRC-1. Scanning downward lets the last hit
    // be the first set bit in upward order.
    function automatic logic [4:0] irq_first_set(input logic [31:0] vec, input int start);
        logic [4:0] idx;
        irq_first_set = 5'(start);
        for (int i = 31; i >= 0; i--) begin
            idx = 5'(start + i);
            if (vec[idx]) irq_first_set = idx;
        end
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchroniser plus history flop, emits the rising-edge vector.
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   raw    asynchronous level inputs
//   rise   one-cycle pulse per bit on a synchronised rising edge
module irq_sync_edge #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync1, sync2, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_q <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            sync2_q <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_q;

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: captures peripheral interrupt edges and hands one at a time to the core's controller.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   irq_src_i       raw asynchronous interrupt lines
//   irq_mask_i      per-source capture enable
//   irq_taken_i     controller accepted the request
//   irq_ret_i       controller returned from the handler
//   irq_req_o       request to the controller
//   irq_id_o        source being requested or serviced
//   irq_ack_o       one-hot acknowledge pulse to the serviced source
//   irq_pending_o   pending register readback
// Define IRQ_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int N_SRC = IRQ_N_SRC_DEFAULT,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [N_SRC-1:0] irq_mask_i,
    input  logic             irq_taken_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [ID_W-1:0]  irq_id_o,
    output logic [N_SRC-1:0] irq_ack_o,
    output logic [N_SRC-1:0] irq_pending_o
);

    logic [N_SRC-1:0] rise, pending_q, clr;
    logic [ID_W-1:0]  id_q, winner;
    irq_state_e       state_q;
    logic             take;

    irq_sync_edge #(.W(N_SRC)) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .raw   (irq_src_i),
        .rise  (rise)
    );

    assign take = state_q == REQ && irq_taken_i;
    assign clr  = take ? N_SRC'(1) << id_q : '0;

`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_q;

    assign winner = ID_W'(irq_first_set(32'(pending_q),
                                        int'(last_q) == N_SRC - 1 ? 0 : int'(last_q) + 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= ID_W'(N_SRC - 1);
        else if (take) last_q <= id_q;
    end
`else
    assign winner = ID_W'(irq_first_set(32'(pending_q), 0));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            id_q      <= '0;
            pending_q <= '0;
        end else begin
            // a fresh edge on the source being taken survives the clear
            pending_q <= (pending_q & ~clr) | (rise & irq_mask_i);
            case (state_q)
                IDLE:    if (|pending_q) begin
                    id_q    <= winner;
                    state_q <= REQ;
                end
                REQ:     if (irq_taken_i) state_q <= SERVICE;
                SERVICE: if (irq_ret_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_req_o     = state_q == REQ;
    assign irq_id_o      = id_q;
    assign irq_ack_o     = clr;
    assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed and random stimulus checked against a behavioural model of irq_arbiter.
module tb_irq_arbiter;

    localparam int N  = 16;
    localparam int IW = $clog2(N);

    logic          clk_i = 0;
    logic          rst_ni = 0;
    logic [N-1:0]  irq_src_i = '0;
    logic [N-1:0]  irq_mask_i = '1;
    logic          irq_taken_i = 0;
    logic          irq_ret_i = 0;
    logic          irq_req_o;
    logic [IW-1:0] irq_id_o;
    logic [N-1:0]  irq_ack_o;
    logic [N-1:0]  irq_pending_o;

    int total = 0;
    int bad = 0;

    // model: samples of the input line taken at the last three edges (index 0 newest)
    logic [N-1:0] hist [3];
    logic [N-1:0] m_pend;
    int           m_state;
    int           m_id;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
    int           m_last;
`endif

    always #5 clk_i = ~clk_i;

    irq_arbiter #(.N_SRC(N)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .irq_src_i     (irq_src_i),
        .irq_mask_i    (irq_mask_i),
        .irq_taken_i   (irq_taken_i),
        .irq_ret_i     (irq_ret_i),
        .irq_req_o     (irq_req_o),
        .irq_id_o      (irq_id_o),
        .irq_ack_o     (irq_ack_o),
        .irq_pending_o (irq_pending_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_pend  = '0;
        m_state = 0;
        m_id    = 0;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        m_last  = N - 1;
`endif
    endtask

    function automatic int pick(input logic [N-1:0] v);
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return 0;
    endfunction

    // one clock: drive at negedge, check outputs, then advance the model across the posedge
    task automatic tick(input logic [N-1:0] src, input logic [N-1:0] mask, input logic tk, input logic rt);
        logic [N-1:0] ack, rise, old;
        @(negedge clk_i);
        irq_src_i   = src;
        irq_mask_i  = mask;
        irq_taken_i = tk;
        irq_ret_i   = rt;
        #1;
        ack = (m_state == 1 && tk) ? N'(1) << m_id : '0;
        check("req", 32'(irq_req_o), 32'(m_state == 1));
        check("id", 32'(irq_id_o), 32'(m_id));
        check("ack", 32'(irq_ack_o), 32'(ack));
        check("pending", 32'(irq_pending_o), 32'(m_pend));
        @(posedge clk_i);
        rise   = hist[1] & ~hist[2];
        old    = m_pend;
        m_pend = (old & ~ack) | (rise & mask);
        if (m_state == 0 && old != 0) begin
            m_id    = pick(old);
            m_state = 1;
        end else if (m_state == 1 && tk) begin
            m_state = 2;
`ifdef IRQ_ARBITER_ROUND_ROBIN_EN
            m_last  = m_id;
`endif
        end else if (m_state == 2 && rt) begin
            m_state = 0;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = src;
    endtask

    task automatic wait_req(input logic [N-1:0] src, input logic [N-1:0] mask);
        int n = 0;
        while (m_state != 1 && n < 12) begin
            tick(src, mask, 1'b0, 1'b0);
            n++;
        end
        #1;
        check("wait_req", 32'(irq_req_o), 32'd1);
    endtask

    task automatic serve(input logic [N-1:0] src, input logic [N-1:0] mask);
        wait_req(src, mask);
        tick(src, mask, 1'b1, 1'b0);
        tick(src, mask, 1'b0, 1'b0);
        tick(src, mask, 1'b0, 1'b1);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick('0, '1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [N-1:0] src;
        model_reset();
        #2;
        check("rst_req", 32'(irq_req_o), 32'd0);
        check("rst_id", 32'(irq_id_o), 32'd0);
        check("rst_ack", 32'(irq_ack_o), 32'd0);
        check("rst_pending", 32'(irq_pending_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_ni = 1;

        // reset pulse while source 3 is being requested
        wait_req(16'h0008, '1);
        #1 rst_ni = 0;
        #1;
        check("midrst_req", 32'(irq_req_o), 32'd0);
        check("midrst_id", 32'(irq_id_o), 32'd0);
        check("midrst_ack", 32'(irq_ack_o), 32'd0);
        check("midrst_pending", 32'(irq_pending_o), 32'd0);
        #1 rst_ni = 1;
        model_reset();
        for (int i = 0; i < 5; i++) tick(16'h0008, '1, 1'b0, 1'b0);
        serve(16'h0008, '1);
        idle_ticks(3);

        // single source 5
        wait_req(16'h0020, '1);
        check("single_id", 32'(irq_id_o), 32'd5);
        tick(16'h0020, '1, 1'b1, 1'b0);
        #1;
        check("single_pend5", 32'(irq_pending_o[5]), 32'd0);
        tick(16'h0020, '1, 1'b0, 1'b0);
        tick(16'h0020, '1, 1'b0, 1'b1);
        idle_ticks(3);

        // simultaneous edges on 2 and 9, back-to-back service
        serve(16'h0204, '1);
        tick(16'h0204, '1, 1'b0, 1'b0);
        serve(16'h0204, '1);
        idle_ticks(3);
        serve(16'h1004, '1);
        tick(16'h1004, '1, 1'b0, 1'b0);
        serve(16'h1004, '1);
        idle_ticks(4);

        // masked edge is discarded; enabling the mask later without a new edge does nothing
        for (int i = 0; i < 5; i++) tick(16'h0080, 16'hff7f, 1'b0, 1'b0);
        #1;
        check("mask_pending", 32'(irq_pending_o), 32'd0);
        for (int i = 0; i < 5; i++) tick(16'h0080, '1, 1'b0, 1'b0);
        #1;
        check("mask_noreq", 32'(irq_req_o), 32'd0);
        idle_ticks(3);

        // new edge on 4 coincides with the take of id 4
        wait_req(16'h0010, '1);
        check("coll_id", 32'(irq_id_o), 32'd4);
        tick('0, '1, 1'b0, 1'b0);
        tick('0, '1, 1'b0, 1'b0);
        tick(16'h0010, '1, 1'b0, 1'b0);
        tick(16'h0010, '1, 1'b0, 1'b0);
        tick(16'h0010, '1, 1'b1, 1'b0);
        #1;
        check("coll_pend4", 32'(irq_pending_o[4]), 32'd1);
        tick(16'h0010, '1, 1'b0, 1'b0);
        tick(16'h0010, '1, 1'b0, 1'b1);
        wait_req(16'h0010, '1);
        check("coll_reid", 32'(irq_id_o), 32'd4);
        serve(16'h0010, '1);
        idle_ticks(3);

        // stray handshakes
        tick('0, '1, 1'b1, 1'b0);
        tick('0, '1, 1'b1, 1'b0);
        wait_req(16'h0001, '1);
        tick(16'h0001, '1, 1'b0, 1'b1);
        #1;
        check("stray_ret", 32'(irq_req_o), 32'd1);
        serve(16'h0001, '1);
        idle_ticks(3);

        // random traffic
        src = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) src = src ^ (N'(1) << $urandom_range(0, N - 1));
            tick(src, ($urandom_range(0, 7) == 0) ? N'($urandom) : '1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
